// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: sequencer state encoding and port ids.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins, a tie goes to the
// port that was not granted last.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_gnt_id,
    output logic       o_gnt_valid
);

    // NOTE: every combinational output is assigned a default first so no latch can be inferred.
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = PORT0;
        if (&i_req) begin
            o_gnt_id = ~i_last_gnt;
        end else if (i_req[1]) begin
            o_gnt_id = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin sequencer in front of a single-port data memory: one-cycle
// mem_r/mem_w strobe, read completion on mem_done, watchdog-terminated reads flagged with err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_m0_req,
    input  logic                i_m0_we,
    input  logic [ADDRSIZE-1:0] i_m0_addr,
    input  logic [WIDTH-1:0]    i_m0_wdata,
    output logic [WIDTH-1:0]    o_m0_rdata,
    output logic                o_m0_ack,
    output logic                o_m0_err,
    input  logic                i_m1_req,
    input  logic                i_m1_we,
    input  logic [ADDRSIZE-1:0] i_m1_addr,
    input  logic [WIDTH-1:0]    i_m1_wdata,
    output logic [WIDTH-1:0]    o_m1_rdata,
    output logic                o_m1_ack,
    output logic                o_m1_err,
    output logic                o_mem_r,
    output logic                o_mem_w,
    output logic [ADDRSIZE-1:0] o_mem_addr,
    output logic [WIDTH-1:0]    o_mem_wdata,
    input  logic [WIDTH-1:0]    i_mem_rdata,
    input  logic                i_mem_done
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t                r_state, w_state_nxt;
    logic                  w_gnt_id, w_gnt_valid;
    logic                  w_sel_we;
    logic [ADDRSIZE-1:0]   w_sel_addr;
    logic [WIDTH-1:0]      w_sel_wdata;
    logic                  w_start, w_finish, w_rd_ok, w_rd_to;
    logic                  r_last_gnt, r_id, r_we;
    logic [CW-1:0]         r_cnt;
    logic                  r_mem_r, r_mem_w;
    logic [ADDRSIZE-1:0]   r_mem_addr;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic [WIDTH-1:0]      r_m0_rdata, r_m1_rdata;
    logic                  r_m0_ack, r_m1_ack, r_m0_err, r_m1_err;

    rr_arb2 u_rr_arb2 (
        .i_req       ({i_m1_req, i_m0_req}),
        .i_last_gnt  (r_last_gnt),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    assign w_sel_we    = (w_gnt_id == PORT1) ? i_m1_we    : i_m0_we;
    assign w_sel_addr  = (w_gnt_id == PORT1) ? i_m1_addr  : i_m0_addr;
    assign w_sel_wdata = (w_gnt_id == PORT1) ? i_m1_wdata : i_m0_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_rd_ok     = 1'b0;
        w_rd_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_done) begin
                    w_rd_ok     = 1'b1;
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_rd_to     = 1'b1;
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the rdata holding registers are reset too, so outputs are defined 0 straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_gnt  <= PORT1;
            r_id        <= PORT0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_r     <= 1'b0;
            r_mem_w     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
            if (w_start) begin
                r_id        <= w_gnt_id;
                r_we        <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_r     <= ~w_sel_we;
                r_mem_w     <= w_sel_we;
            end
            if (r_state == S_ISSUE) begin
                r_mem_r    <= 1'b0;
                r_mem_w    <= 1'b0;
                r_last_gnt <= r_id;
                r_cnt      <= '0;
            end
            if (r_state == S_WAIT && !i_mem_done && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Completion: pulse the winner's ack; a timed-out read leaves its rdata untouched.
            if (w_finish) begin
                if (r_id == PORT1) begin
                    r_m1_ack <= 1'b1;
                    r_m1_err <= w_rd_to;
                end else begin
                    r_m0_ack <= 1'b1;
                    r_m0_err <= w_rd_to;
                end
            end
            if (w_rd_ok) begin
                if (r_id == PORT1) begin
                    r_m1_rdata <= i_mem_rdata;
                end else begin
                    r_m0_rdata <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_r     = r_mem_r;
    assign o_mem_w     = r_mem_w;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_m0_ack    = r_m0_ack;
    assign o_m1_ack    = r_m1_ack;
    assign o_m0_err    = r_m0_err;
    assign o_m1_err    = r_m1_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, scoreboard of expected
// acks, and directed scenarios for reset, round robin, watchdog and request latching.
module tb_mem_arbiter;

    localparam int W      = 32;
    localparam int AW     = 32;
    localparam int TO     = 15;
    localparam int MAXLAT = 40;

    typedef struct {
        logic          port;
        logic          err;
        logic [W-1:0]  rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [W-1:0]  m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [W-1:0]  m1_wdata = '0;
    logic [W-1:0]  m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic          mem_r, mem_w;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_done = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t         sb[$];
    logic [W-1:0] ref_mem [16];
    logic [W-1:0] held [2];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .ADDRSIZE(AW), .TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_m0_req    (m0_req),
        .i_m0_we     (m0_we),
        .i_m0_addr   (m0_addr),
        .i_m0_wdata  (m0_wdata),
        .o_m0_rdata  (m0_rdata),
        .o_m0_ack    (m0_ack),
        .o_m0_err    (m0_err),
        .i_m1_req    (m1_req),
        .i_m1_we     (m1_we),
        .i_m1_addr   (m1_addr),
        .i_m1_wdata  (m1_wdata),
        .o_m1_rdata  (m1_rdata),
        .o_m1_ack    (m1_ack),
        .o_m1_err    (m1_err),
        .o_mem_r     (mem_r),
        .o_mem_w     (mem_w),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_done  (mem_done)
    );

    function automatic logic [W-1:0] init_val(input int a);
        return 32'h1000_0000 + W'(a);
    endfunction

    // Memory model: unwritten words read back as init_val, mem_done one cycle after mem_r.
    logic [W-1:0]  mem [16];
    logic [15:0]   wr_mask = '0;
    logic          suppress_done = 1'b0;
    int            rd_cnt = 0;
    int            overlap_cnt = 0;
    logic [AW-1:0] rd_addr_last = '0;

    always @(posedge clk) begin
        if (mem_w) begin
            mem[mem_addr[3:0]]     <= mem_wdata;
            wr_mask[mem_addr[3:0]] <= 1'b1;
        end
        if (mem_r) begin
            mem_rdata    <= wr_mask[mem_addr[3:0]] ? mem[mem_addr[3:0]] : init_val(int'(mem_addr[3:0]));
            rd_cnt       <= rd_cnt + 1;
            rd_addr_last <= mem_addr;
        end
        if (mem_r && mem_w) overlap_cnt <= overlap_cnt + 1;
        mem_done <= mem_r && !suppress_done;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    exp_t e;
    logic prev_m0_ack = 1'b0;
    logic prev_m1_ack = 1'b0;
    int   ack_viol = 0;

    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("ack_port", m1_ack, e.port);
                check("ack_single", m0_ack & m1_ack, 1'b0);
                check("ack_err", m1_ack ? m1_err : m0_err, e.err);
                check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
            end
        end
        if ((m0_ack && prev_m0_ack) || (m1_ack && prev_m1_ack)) ack_viol++;
        prev_m0_ack = m0_ack;
        prev_m1_ack = m1_ack;
    end

    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [W-1:0] wdata);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic push_exp(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [W-1:0] wdata, input logic err);
        exp_t ent;
        if (we) ref_mem[addr[3:0]] = wdata;
        else if (!err) held[port] = ref_mem[addr[3:0]];
        ent.port  = port;
        ent.err   = we ? 1'b0 : err;
        ent.rdata = held[port];
        sb.push_back(ent);
    endtask

    task automatic do_req(input string tag, input logic port, input logic we,
                          input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                          input logic err, input int exp_lat,
                          input logic swap, input logic [AW-1:0] new_addr);
        int lat = 0;
        push_exp(port, we, addr, wdata, err);
        @(posedge clk); #1;
        set_port(port, 1'b1, we, addr, wdata);
        @(posedge clk);
        if (swap) begin
            #1;
            if (port) m1_addr = new_addr; else m0_addr = new_addr;
        end
        for (int k = 1; k <= MAXLAT; k++) begin
            @(negedge clk);
            if (port ? m1_ack : m0_ack) begin
                lat = k;
                break;
            end
        end
        set_port(port, 1'b0, 1'b0, '0, '0);
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic wait_acks(input string tag, input int n);
        int seen = 0;
        for (int k = 0; k < 200 && seen < n; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) seen++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, "_acks"}, seen, n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0;
        int cnt;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        held[0] = '0;
        held[1] = '0;

        // Reset with both ports requesting; port0 must win the first grant.
        rst_n = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 4, '0);
        set_port(1'b1, 1'b1, 1'b0, 6, '0);
        push_exp(1'b0, 1'b0, 4, '0, 1'b0);
        push_exp(1'b1, 1'b0, 6, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", |{m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
                               mem_r, mem_w, mem_addr, mem_wdata}, 1'b0);
        rst_n = 1'b1;
        wait_acks("t1", 2);

        // Port1 write then read-back.
        do_req("t2_wr", 1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, '0);
        do_req("t2_rd", 1'b1, 1'b0, 5, '0, 1'b0, 3, 1'b0, '0);
        check("t2_rdata", m1_rdata, 32'hDEAD_BEEF);

        // Both ports hold read requests: grants alternate 0,1,0,1.
        n0 = rd_cnt;
        push_exp(1'b0, 1'b0, 1, '0, 1'b0);
        push_exp(1'b1, 1'b0, 2, '0, 1'b0);
        push_exp(1'b0, 1'b0, 1, '0, 1'b0);
        push_exp(1'b1, 1'b0, 2, '0, 1'b0);
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 1, '0);
        set_port(1'b1, 1'b1, 1'b0, 2, '0);
        wait_acks("t3", 4);
        repeat (2) @(negedge clk);
        check("t3_mem_r_pulses", rd_cnt - n0, 4);

        // Watchdog: no mem_done, err after TIMEOUT wait cycles, rdata held.
        suppress_done = 1'b1;
        do_req("t4_timeout", 1'b0, 1'b0, 3, '0, 1'b1, TO + 2, 1'b0, '0);
        suppress_done = 1'b0;
        check("t4_rdata_held", m0_rdata, init_val(1));
        do_req("t4_recover", 1'b0, 1'b0, 3, '0, 1'b0, 3, 1'b0, '0);

        // Reset while a port0 read sits in WAIT: the read is dropped.
        suppress_done = 1'b1;
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 8, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        check("t5_mem_r_after_rst", mem_r, 1'b0);
        check("t5_outputs_after_rst", |{m0_ack, m0_err, m0_rdata, m1_rdata, mem_w}, 1'b0);
        rst_n = 1'b1;
        held[0] = '0;
        held[1] = '0;
        suppress_done = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (m0_ack) cnt++;
        end
        check("t5_no_ack", cnt, 0);
        do_req("t5_p1", 1'b1, 1'b0, 5, '0, 1'b0, 3, 1'b0, '0);

        // Address change after sampling must not reach the memory.
        n0 = rd_cnt;
        do_req("t6", 1'b0, 1'b0, 7, '0, 1'b0, 3, 1'b1, 9);
        check("t6_reads", rd_cnt - n0, 1);
        check("t6_addr", rd_addr_last, 7);

        repeat (3) @(negedge clk);
        check("rw_overlap", overlap_cnt, 0);
        check("ack_width", ack_viol, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
